video_timing_pattern_gen: RTL and testbench

//  Parametrised raster timing generator and test-pattern source for the HDMI transmitter
//  (ADV7511) output path. Supports any raster size/porch/sync timing and selectable sync

---
 rtl/video_timing_pattern_gen.sv | 193 +++++++++++++++++++
 tb/tb_video_timing_pattern_gen.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_pattern_gen.sv
// Raster timing generator with eight test patterns; 2 pix_clk latency from counters to pins.
// No backpressure: once enabled the raster free-runs and only stops on a frame boundary.
module video_timing_pattern_gen #(
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int DW       = 16,
  parameter int BOX      = 128
) (
  input  logic          pix_clk,
  input  logic          pix_rstn,
  input  logic          enable,
  input  logic [3:0]    mode,
  input  logic [DW-1:0] solid,
  output logic          vid_de,
  output logic          vid_hs,
  output logic          vid_vs,
  output logic [DW-1:0] vid_data,
  output logic          sof,
  output logic [15:0]   frame_cnt,
  output logic          running
);

  localparam int H_TOT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW     = $clog2(H_TOT);
  localparam int VW     = $clog2(V_TOT);
  localparam int HS_BEG = H_ACTIVE + H_FP;
  localparam int HS_END = HS_BEG + H_SYNC;
  localparam int VS_BEG = V_ACTIVE + V_FP;
  localparam int VS_END = VS_BEG + V_SYNC;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nxt;

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          cnt_vld, line_end, frame_end, frame_start;
  logic [3:0]    mode_q, mode_cur;
  logic [HW-1:0] bx;
  logic [VW-1:0] by;
  logic          bx_neg, by_neg, bx_neg_nxt, by_neg_nxt;

  assign cnt_vld     = (state != IDLE);
  assign line_end    = (32'(hcnt) == H_TOT - 1);
  assign frame_end   = cnt_vld && line_end && (32'(vcnt) == V_TOT - 1);
  assign frame_start = cnt_vld && (hcnt == '0) && (vcnt == '0);
  assign running     = cnt_vld;
  assign mode_cur    = frame_start ? mode : mode_q;

  // Dropping enable on the very last cycle skips DRAIN so no extra frame starts.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = RUN;
      RUN:     if (!enable) state_nxt = frame_end ? IDLE : DRAIN;
      DRAIN: begin
        if (enable)         state_nxt = RUN;
        else if (frame_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pix_clk or negedge pix_rstn) begin
    if (!pix_rstn) state <= IDLE;
    else           state <= state_nxt;
  end

  // Counters sit at (0,0) whenever idle because frames always end on a wrap.
  always_ff @(posedge pix_clk or negedge pix_rstn) begin
    if (!pix_rstn) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (cnt_vld) begin
      if (line_end) begin
        hcnt <= '0;
        vcnt <= frame_end ? '0 : vcnt + 1'b1;
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge pix_clk or negedge pix_rstn) begin
    if (!pix_rstn)        mode_q <= 4'd0;
    else if (frame_start) mode_q <= mode;
  end

  always_comb begin
    bx_neg_nxt = bx_neg;
    if (!bx_neg && (32'(bx) + BOX == H_ACTIVE)) bx_neg_nxt = 1'b1;
    else if (bx_neg && (bx == '0))              bx_neg_nxt = 1'b0;
    by_neg_nxt = by_neg;
    if (!by_neg && (32'(by) + BOX == V_ACTIVE)) by_neg_nxt = 1'b1;
    else if (by_neg && (by == '0))              by_neg_nxt = 1'b0;
  end

  always_ff @(posedge pix_clk or negedge pix_rstn) begin
    if (!pix_rstn) begin
      bx     <= '0;
      by     <= '0;
      bx_neg <= 1'b0;
      by_neg <= 1'b0;
    end else if (frame_end) begin
      bx     <= bx_neg_nxt ? bx - 1'b1 : bx + 1'b1;
      by     <= by_neg_nxt ? by - 1'b1 : by + 1'b1;
      bx_neg <= bx_neg_nxt;
      by_neg <= by_neg_nxt;
    end
  end

  logic [8:0]    hx, vx;
  logic [2:0]    bar;
  logic          in_box, d_de, d_hs, d_vs, d_sof;
  logic [7:0]    luma;
  logic [DW-1:0] pix;

  always_comb begin
    hx    = 9'(hcnt);
    vx    = 9'(vcnt);
    d_de  = cnt_vld && (32'(hcnt) < H_ACTIVE) && (32'(vcnt) < V_ACTIVE);
    d_hs  = cnt_vld && (32'(hcnt) >= HS_BEG) && (32'(hcnt) < HS_END);
    d_vs  = cnt_vld && (32'(vcnt) >= VS_BEG) && (32'(vcnt) < VS_END);
    d_sof = frame_start;
    // Bar index = number of bar edges already passed; avoids a real divider.
    bar = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (32'(hcnt) * 8 >= k * H_ACTIVE) bar = bar + 3'd1;
    end
    in_box = (32'(hcnt) >= 32'(bx)) && (32'(hcnt) < 32'(bx) + BOX) &&
             (32'(vcnt) >= 32'(by)) && (32'(vcnt) < 32'(by) + BOX);
    case (mode_cur)
      4'd0:    luma = hx[7:0];
      4'd1:    luma = vx[7:0];
      4'd2:    luma = hx[8:1];
      4'd3:    luma = vx[8:1];
      4'd4:    luma = 8'hFF - {bar, 5'd0};
      4'd6:    luma = in_box ? 8'hFF : 8'h10;
      4'd7:    luma = {8{hx[5] ^ vx[5]}};
      default: luma = 8'h00;
    endcase
    if (DW == 24) pix = DW'({luma, luma, luma});
    else          pix = DW'({8'h80, luma});
    if (mode_cur == 4'd5) pix = solid;
    if (!d_de)            pix = '0;
  end

  logic          s1_de, s1_hs, s1_vs, s1_sof;
  logic [DW-1:0] s1_data;

  always_ff @(posedge pix_clk or negedge pix_rstn) begin
    if (!pix_rstn) begin
      s1_de   <= 1'b0;
      s1_hs   <= 1'b0;
      s1_vs   <= 1'b0;
      s1_sof  <= 1'b0;
      s1_data <= '0;
    end else begin
      s1_de   <= d_de;
      s1_hs   <= d_hs;
      s1_vs   <= d_vs;
      s1_sof  <= d_sof;
      s1_data <= pix;
    end
  end

  always_ff @(posedge pix_clk or negedge pix_rstn) begin
    if (!pix_rstn) begin
      vid_de    <= 1'b0;
      vid_hs    <= ~HS_POL;
      vid_vs    <= ~VS_POL;
      vid_data  <= '0;
      sof       <= 1'b0;
      frame_cnt <= 16'd0;
    end else begin
      vid_de   <= s1_de;
      vid_hs   <= s1_hs ? HS_POL : ~HS_POL;
      vid_vs   <= s1_vs ? VS_POL : ~VS_POL;
      vid_data <= s1_data;
      sof      <= s1_sof;
      if (s1_sof) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_video_timing_pattern_gen.sv
// Directed bench: small rasters (A: 14x7, B: 20x11) for full-frame checks, default raster for two lines.
module tb_video_timing_pattern_gen;
  logic pix_clk = 1'b0;
  logic pix_rstn = 1'b0;
  always #5 pix_clk = ~pix_clk;

  int errors = 0;
  int checks = 0;

  logic        en_a = 1'b0;
  logic [3:0]  mode_a = 4'd0;
  logic [15:0] solid_a = 16'h1234;
  logic        de_a, hs_a, vs_a, sof_a, run_a;
  logic [15:0] data_a, fc_a;

  logic        en_b = 1'b0;
  logic [3:0]  mode_b = 4'd0;
  logic [23:0] solid_b = 24'hA5C3E1;
  logic        de_b, hs_b, vs_b, sof_b, run_b;
  logic [23:0] data_b;
  logic [15:0] fc_b;

  logic        en_c = 1'b0;
  logic [3:0]  mode_c = 4'd0;
  logic [15:0] solid_c = 16'h0000;
  logic        de_c, hs_c, vs_c, sof_c, run_c;
  logic [15:0] data_c, fc_c;

  video_timing_pattern_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1),
    .DW(16), .BOX(2)) u_a (
    .pix_clk(pix_clk), .pix_rstn(pix_rstn), .enable(en_a), .mode(mode_a), .solid(solid_a),
    .vid_de(de_a), .vid_hs(hs_a), .vid_vs(vs_a), .vid_data(data_a), .sof(sof_a),
    .frame_cnt(fc_a), .running(run_a));

  video_timing_pattern_gen #(.H_ACTIVE(16), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0),
    .DW(24), .BOX(4)) u_b (
    .pix_clk(pix_clk), .pix_rstn(pix_rstn), .enable(en_b), .mode(mode_b), .solid(solid_b),
    .vid_de(de_b), .vid_hs(hs_b), .vid_vs(vs_b), .vid_data(data_b), .sof(sof_b),
    .frame_cnt(fc_b), .running(run_b));

  video_timing_pattern_gen u_c (
    .pix_clk(pix_clk), .pix_rstn(pix_rstn), .enable(en_c), .mode(mode_c), .solid(solid_c),
    .vid_de(de_c), .vid_hs(hs_c), .vid_vs(vs_c), .vid_data(data_c), .sof(sof_c),
    .frame_cnt(fc_c), .running(run_c));

  // Expected {de,hs,vs} pin levels for output index n of a frame.
  function automatic logic [2:0] tim_a(input int n);
    int h, v;
    h = n % 14;
    v = n / 14;
    return {1'(h < 8 && v < 4), 1'(h >= 10 && h < 12), 1'(v == 5)};
  endfunction

  function automatic logic [2:0] tim_b(input int n);
    int h, v;
    h = n % 20;
    v = n / 20;
    return {1'(h < 16 && v < 8), 1'(!(h >= 17 && h < 19)), 1'(v != 9)};
  endfunction

  function automatic logic [7:0] pat_y(input int md, input int h, input int v,
                                       input int hact, input bit inbox);
    case (md)
      0:       return 8'(h);
      1:       return 8'(v);
      2:       return 8'(h >> 1);
      3:       return 8'(v >> 1);
      4:       return 8'(255 - 32 * ((h * 8) / hact));
      6:       return inbox ? 8'hFF : 8'h10;
      7:       return ((((h >> 5) ^ (v >> 5)) & 1) != 0) ? 8'hFF : 8'h00;
      default: return 8'h00;
    endcase
  endfunction

  task automatic test_reset();
    @(negedge pix_clk);
    checks++; if ({de_a, hs_a, vs_a, sof_a, run_a} !== 5'b00000) begin errors++;
      $display("FAIL reset_ctl_a: got %b want 00000", {de_a, hs_a, vs_a, sof_a, run_a}); end
    checks++; if (data_a !== 16'h0 || fc_a !== 16'h0) begin errors++;
      $display("FAIL reset_data_a: got data %h cnt %h want 0000 0000", data_a, fc_a); end
    checks++; if ({de_b, hs_b, vs_b, sof_b, run_b} !== 5'b01100) begin errors++;
      $display("FAIL reset_ctl_b: got %b want 01100", {de_b, hs_b, vs_b, sof_b, run_b}); end
    checks++; if (data_b !== 24'h0 || fc_b !== 16'h0) begin errors++;
      $display("FAIL reset_data_b: got data %h cnt %h want 0 0", data_b, fc_b); end
    checks++; if ({de_c, hs_c, vs_c, sof_c, run_c, data_c} !== 21'h0) begin errors++;
      $display("FAIL reset_c: got %b %h want 00000 0000", {de_c, hs_c, vs_c, sof_c, run_c}, data_c); end
    pix_rstn = 1'b1;
  endtask

  task automatic test_default_line();
    int h, de_cnt, hs_cnt;
    logic [15:0] dexp;
    de_cnt = 0;
    hs_cnt = 0;
    @(negedge pix_clk); en_c = 1'b1; mode_c = 4'd0;
    repeat (2) @(negedge pix_clk);
    for (int n = 0; n < 4400; n++) begin
      @(negedge pix_clk);
      h = n % 2200;
      if (h == 0) begin de_cnt = 0; hs_cnt = 0; end
      de_cnt += int'(de_c);
      hs_cnt += int'(hs_c);
      dexp = (h < 1920) ? {8'h80, 8'(h)} : 16'h0;
      checks++; if ({de_c, hs_c, vs_c, sof_c} !== {1'(h < 1920), 1'(h >= 2008 && h < 2052), 1'b0, 1'(n == 0)}) begin
        errors++; $display("FAIL dflt_ctl n=%0d: got %b", n, {de_c, hs_c, vs_c, sof_c}); end
      checks++; if (data_c !== dexp) begin errors++;
        $display("FAIL dflt_data n=%0d: got %h want %h", n, data_c, dexp); end
      if (h == 2199) begin
        checks++; if (de_cnt != 1920) begin errors++;
          $display("FAIL dflt_de_count: got %0d want 1920", de_cnt); end
        checks++; if (hs_cnt != 44) begin errors++;
          $display("FAIL dflt_hs_count: got %0d want 44", hs_cnt); end
      end
    end
    en_c = 1'b0;
  endtask

  task automatic test_bars();
    int h, v;
    logic [15:0] dexp;
    @(negedge pix_clk); en_a = 1'b1; mode_a = 4'd4;
    repeat (2) @(negedge pix_clk);
    checks++; if ({de_a, sof_a} !== 2'b00) begin errors++;
      $display("FAIL bars_latency: got de/sof %b want 00", {de_a, sof_a}); end
    for (int n = 0; n < 98; n++) begin
      @(negedge pix_clk);
      h = n % 14; v = n / 14;
      dexp = (h < 8 && v < 4) ? {8'h80, pat_y(4, h, v, 8, 1'b0)} : 16'h0;
      checks++; if ({de_a, hs_a, vs_a} !== tim_a(n)) begin errors++;
        $display("FAIL bars_timing n=%0d: got %b want %b", n, {de_a, hs_a, vs_a}, tim_a(n)); end
      checks++; if (data_a !== dexp) begin errors++;
        $display("FAIL bars_data n=%0d: got %h want %h", n, data_a, dexp); end
      checks++; if ({sof_a, run_a, fc_a} !== {1'(n == 0), 1'b1, 16'd1}) begin errors++;
        $display("FAIL bars_sof n=%0d: got sof %b run %b cnt %0d", n, sof_a, run_a, fc_a); end
      if (n == 30) mode_a = 4'd0;
    end
  endtask

  task automatic test_mode_switch();
    int h, v;
    logic [15:0] dexp;
    for (int n = 0; n < 98; n++) begin
      @(negedge pix_clk);
      h = n % 14; v = n / 14;
      dexp = (h < 8 && v < 4) ? {8'h80, pat_y(0, h, v, 8, 1'b0)} : 16'h0;
      checks++; if ({de_a, hs_a, vs_a} !== tim_a(n)) begin errors++;
        $display("FAIL switch_timing n=%0d: got %b want %b", n, {de_a, hs_a, vs_a}, tim_a(n)); end
      checks++; if (data_a !== dexp) begin errors++;
        $display("FAIL switch_data n=%0d: got %h want %h", n, data_a, dexp); end
      checks++; if ({sof_a, fc_a} !== {1'(n == 0), 16'd2}) begin errors++;
        $display("FAIL switch_sof n=%0d: got sof %b cnt %0d", n, sof_a, fc_a); end
      if (n == 30) mode_a = 4'd1;
    end
  endtask

  task automatic test_stop_drain();
    int h, v;
    logic [15:0] dexp;
    for (int n = 0; n < 98; n++) begin
      @(negedge pix_clk);
      h = n % 14; v = n / 14;
      dexp = (h < 8 && v < 4) ? {8'h80, pat_y(1, h, v, 8, 1'b0)} : 16'h0;
      checks++; if ({de_a, hs_a, vs_a} !== tim_a(n)) begin errors++;
        $display("FAIL drain_timing n=%0d: got %b want %b", n, {de_a, hs_a, vs_a}, tim_a(n)); end
      checks++; if (data_a !== dexp) begin errors++;
        $display("FAIL drain_data n=%0d: got %h want %h", n, data_a, dexp); end
      checks++; if ({sof_a, run_a, fc_a} !== {1'(n == 0), 1'(n <= 95), 16'd3}) begin errors++;
        $display("FAIL drain_run n=%0d: got sof %b run %b cnt %0d", n, sof_a, run_a, fc_a); end
      if (n == 16) en_a = 1'b0;
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge pix_clk);
      checks++; if ({de_a, hs_a, vs_a, sof_a, run_a, data_a, fc_a} !== {5'b00000, 16'h0, 16'd3}) begin
        errors++; $display("FAIL drain_idle i=%0d: got %b %h cnt %0d", i,
          {de_a, hs_a, vs_a, sof_a, run_a}, data_a, fc_a); end
    end
  endtask

  task automatic test_reset_midline();
    @(negedge pix_clk); en_a = 1'b1; mode_a = 4'd0;
    repeat (23) @(negedge pix_clk);
    checks++; if ({de_a, fc_a} !== {1'b1, 16'd4}) begin errors++;
      $display("FAIL rst_pre: got de %b cnt %0d want 1 4", de_a, fc_a); end
    #2 pix_rstn = 1'b0;
    en_a = 1'b0;
    #1;
    checks++; if ({de_a, hs_a, vs_a, sof_a, run_a, data_a, fc_a} !== 37'h0) begin errors++;
      $display("FAIL rst_async: got %b %h cnt %0d", {de_a, hs_a, vs_a, sof_a, run_a}, data_a, fc_a); end
    @(negedge pix_clk); pix_rstn = 1'b1;
    @(negedge pix_clk); en_a = 1'b1;
    repeat (2) @(negedge pix_clk);
    checks++; if ({de_a, sof_a, fc_a} !== 18'h0) begin errors++;
      $display("FAIL rst_restart_pre: got de %b sof %b cnt %0d", de_a, sof_a, fc_a); end
    for (int n = 0; n < 14; n++) begin
      @(negedge pix_clk);
      checks++; if ({de_a, hs_a, vs_a} !== tim_a(n)) begin errors++;
        $display("FAIL rst_timing n=%0d: got %b want %b", n, {de_a, hs_a, vs_a}, tim_a(n)); end
      checks++; if (data_a !== ((n < 8) ? {8'h80, 8'(n)} : 16'h0)) begin errors++;
        $display("FAIL rst_data n=%0d: got %h", n, data_a); end
      checks++; if ({sof_a, fc_a} !== {1'(n == 0), 16'd1}) begin errors++;
        $display("FAIL rst_sof n=%0d: got sof %b cnt %0d", n, sof_a, fc_a); end
    end
    en_a = 1'b0;
  endtask

  task automatic test_box();
    int h, v, bx, by;
    bit bxn, byn, inb;
    logic [7:0]  y;
    logic [23:0] dexp;
    bx = 0; by = 0; bxn = 1'b0; byn = 1'b0;
    @(negedge pix_clk); en_b = 1'b1; mode_b = 4'd6;
    repeat (2) @(negedge pix_clk);
    for (int f = 0; f < 26; f++) begin
      for (int n = 0; n < 220; n++) begin
        @(negedge pix_clk);
        h = n % 20; v = n / 20;
        inb = (h >= bx && h < bx + 4 && v >= by && v < by + 4);
        y = pat_y(6, h, v, 16, inb);
        dexp = (h < 16 && v < 8) ? {y, y, y} : 24'h0;
        checks++; if ({de_b, hs_b, vs_b} !== tim_b(n)) begin errors++;
          $display("FAIL box_timing f=%0d n=%0d: got %b want %b", f, n, {de_b, hs_b, vs_b}, tim_b(n)); end
        checks++; if (data_b !== dexp) begin errors++;
          $display("FAIL box_data f=%0d h=%0d v=%0d: got %h want %h", f, h, v, data_b, dexp); end
        checks++; if ({sof_b, fc_b} !== {1'(n == 0), 16'(f + 1)}) begin errors++;
          $display("FAIL box_sof f=%0d n=%0d: got sof %b cnt %0d", f, n, sof_b, fc_b); end
        if (f == 25 && n == 100) mode_b = 4'd2;
      end
      if (!bxn && bx + 4 == 16) bxn = 1'b1; else if (bxn && bx == 0) bxn = 1'b0;
      if (!byn && by + 4 == 8)  byn = 1'b1; else if (byn && by == 0) byn = 1'b0;
      bx = bxn ? bx - 1 : bx + 1;
      by = byn ? by - 1 : by + 1;
    end
  endtask

  task automatic test_modes_b();
    int h, v, md;
    int md_list[5] = '{2, 3, 5, 7, 12};
    logic [7:0]  y;
    logic [23:0] dexp;
    for (int i = 0; i < 5; i++) begin
      md = md_list[i];
      for (int n = 0; n < 220; n++) begin
        @(negedge pix_clk);
        h = n % 20; v = n / 20;
        y = pat_y(md, h, v, 16, 1'b0);
        dexp = (h < 16 && v < 8) ? ((md == 5) ? solid_b : {y, y, y}) : 24'h0;
        checks++; if (data_b !== dexp) begin errors++;
          $display("FAIL modes_data m=%0d h=%0d v=%0d: got %h want %h", md, h, v, data_b, dexp); end
        checks++; if ({de_b, sof_b, fc_b} !== {1'(h < 16 && v < 8), 1'(n == 0), 16'(27 + i)}) begin
          errors++; $display("FAIL modes_ctl m=%0d n=%0d: got de %b sof %b cnt %0d", md, n, de_b, sof_b, fc_b); end
        if (n == 100 && i < 4) mode_b = 4'(md_list[i + 1]);
      end
    end
    en_b = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_default_line();
    test_bars();
    test_mode_switch();
    test_stop_drain();
    test_reset_midline();
    test_box();
    test_modes_b();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
